// File: rtl/load_scoreboard_hazard_unit.sv
// Purpose : per-register load scoreboard; stalls the front end on load-use and load-capacity hazards.
// Latency : lockers/bubble are combinational this cycle; scoreboard and counter update on the next clk edge.
// Backpres: holds PC, IF/ID and DEC (lockers = 0) and bubbles DEC_ALU while a hazard persists; DEC_ALU never stalls.
//
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   id_*                  - decoder instruction: valid, is_load, sources rs1/rs2 with read enables
//   ex_valid/ex_is_load/ex_rd - DEC_ALU instruction issuing this cycle (a load issue marks ex_rd pending)
//   mem_resp_valid/_rd    - returning load response (clears pending, decrements outstanding)
//   flush                 - branch redirect; drops the decoder instruction and therefore its stall
//   pc_locker/if_id_locker/dec_locker - 1 = advance, 0 = hold
//   ex_bubble             - insert NOP into DEC_ALU next cycle
//   outstanding           - number of loads in flight
//
// Optional feature macro: HAZARD_RESP_BYPASS_EN
//   defined   : a response in the current cycle resolves the source hazard immediately
//               (the write-back value is forwarded to the dependent instruction).
//   undefined : the dependent instruction advances one cycle after the response.
//   The capacity hazard never uses a same-cycle response in either mode.

module load_scoreboard_hazard_unit #(
    parameter int REG_ADDR_W      = 5,
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic                  id_is_load,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_rs1_en,
    input  logic                  id_rs2_en,
    input  logic                  ex_valid,
    input  logic                  ex_is_load,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  mem_resp_valid,
    input  logic [REG_ADDR_W-1:0] mem_resp_rd,
    input  logic                  flush,
    output logic                  pc_locker,
    output logic                  if_id_locker,
    output logic                  dec_locker,
    output logic                  ex_bubble,
    output logic [CNT_W-1:0]      outstanding
);

    localparam int NREGS = 1 << REG_ADDR_W;
    localparam logic [CNT_W:0]   MAX_C   = (CNT_W+1)'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] CNT_TOP = '1;

    logic [NREGS-1:0] pending_q, pending_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;

    logic             ld_iss;
    logic [NREGS-1:0] pending_eff;
    logic [CNT_W:0]   cnt_with_issue;
    logic             hz_rs1, hz_rs2, hz_cap, stall;

    always_comb begin
        ld_iss         = ex_valid & ex_is_load;
        pending_d      = pending_q;
        outstanding_d  = outstanding_q;
        pending_eff    = pending_q;
        cnt_with_issue = '0;
        hz_rs1         = 1'b0;
        hz_rs2         = 1'b0;
        hz_cap         = 1'b0;
        stall          = 1'b0;

        // Clear first, then set, so an issue and a response to the same
        // register in one cycle leaves the register pending.
        if (mem_resp_valid) begin
            pending_d[mem_resp_rd] = 1'b0;
        end
        if (ld_iss && (ex_rd != '0)) begin
            pending_d[ex_rd] = 1'b1;
        end

        // Issue and response together cancel out. A lone response
        // saturates at zero so stray/late responses cannot underflow.
        // The increment also saturates as a guard, though the capacity
        // hazard keeps the count at or below MAX_OUTSTANDING in practice.
        if (ld_iss && !mem_resp_valid) begin
            if (outstanding_q != CNT_TOP) begin
                outstanding_d = outstanding_q + CNT_W'(1);
            end
        end else if (!ld_iss && mem_resp_valid) begin
            if (outstanding_q != '0) begin
                outstanding_d = outstanding_q - CNT_W'(1);
            end
        end

`ifdef HAZARD_RESP_BYPASS_EN
        if (mem_resp_valid) begin
            pending_eff[mem_resp_rd] = 1'b0;
        end
`endif

        // A load issuing this cycle is not in the scoreboard yet, so it is
        // matched directly against ex_rd. x0 never hazards.
        hz_rs1 = id_rs1_en && (id_rs1 != '0) &&
                 (pending_eff[id_rs1] || (ld_iss && (ex_rd == id_rs1)));
        hz_rs2 = id_rs2_en && (id_rs2 != '0) &&
                 (pending_eff[id_rs2] || (ld_iss && (ex_rd == id_rs2)));

        // Capacity looks at the registered count plus this cycle's issue;
        // a same-cycle response is deliberately not credited.
        cnt_with_issue = {1'b0, outstanding_q} + {{CNT_W{1'b0}}, ld_iss};
        hz_cap         = id_is_load && (cnt_with_issue >= MAX_C);

        stall = id_valid && !flush && !rst && (hz_rs1 || hz_rs2 || hz_cap);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q     <= '0;
            outstanding_q <= '0;
        end else begin
            pending_q     <= pending_d;
            outstanding_q <= outstanding_d;
        end
    end

    assign pc_locker    = ~stall;
    assign if_id_locker = ~stall;
    assign dec_locker   = ~stall;
    assign ex_bubble    = stall;
    assign outstanding  = outstanding_q;

endmodule
